// File: rtl/fir_host_seq.sv
// Host-side sequencer for the 2D FIR matrix core: holds one tap set and one frame,
// streams them into the core's shift chains, and collects the result stream.
module fir_host_seq #(
  parameter int TAP_ROW    = 3,
  parameter int TAP_COL    = 3,
  parameter int TAP_WIDTH  = 8,
  parameter int DATA_ROW   = 16,
  parameter int DATA_COL   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 4096,
  localparam int NT   = TAP_ROW * TAP_COL,
  localparam int ND   = DATA_ROW * DATA_COL,
  localparam int NR   = (DATA_ROW - TAP_ROW + 1) * (DATA_COL - TAP_COL + 1),
  localparam int TA_W = $clog2(NT),
  localparam int DA_W = $clog2(ND),
  localparam int RA_W = $clog2(NR),
  localparam int RC_W = $clog2(NR + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tap_wr_i,
  input  logic [TA_W-1:0]       tap_addr_i,
  input  logic [TAP_WIDTH-1:0]  tap_wdata_i,
  input  logic                  data_wr_i,
  input  logic [DA_W-1:0]       data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic [RA_W-1:0]       res_addr_i,
  output logic [31:0]           res_data_o,
  output logic [RC_W-1:0]       res_count_o,
  output logic [TAP_WIDTH-1:0]  tap_o,
  output logic                  tap_vld_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_vld_o,
  input  logic [31:0]           result_i,
  input  logic                  result_vld_i,
  input  logic                  result_finish_i
);

  if (DATA_ROW * DATA_COL > 256) begin : g_frame_too_big
    $error("fir_host_seq: DATA_ROW*DATA_COL exceeds the core FIFO depth of 256");
  end

  localparam int CNT_MAX = (NT > ND) ? NT : ND;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] NT_C    = CNT_W'(NT);
  localparam logic [CNT_W-1:0] ND_C    = CNT_W'(ND);
  localparam logic [RC_W-1:0]  NR_C    = RC_W'(NR);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAP,
    ST_DATA,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [TO_W-1:0]       wait_q, wait_d;
  logic [RC_W-1:0]       res_count_q, res_count_d;
  logic                  err_q, err_d;
  logic                  tap_vld_q, tap_vld_d;
  logic [TAP_WIDTH-1:0]  tap_q, tap_d;
  logic                  data_vld_q, data_vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           res_data_q, res_data_d;

  logic [TAP_WIDTH-1:0]  tap_mem  [NT];
  logic [DATA_WIDTH-1:0] data_mem [ND];
  logic [31:0]           res_mem  [NR];

  logic                  tap_we, data_we, res_we;
  logic [TA_W-1:0]       tap_ra;
  logic [DA_W-1:0]       data_ra;
  logic [TAP_WIDTH-1:0]  tap_rd;
  logic [DATA_WIDTH-1:0] data_rd;

  assign tap_we  = tap_wr_i  && (state_q == ST_IDLE) && (int'(tap_addr_i)  < NT);
  assign data_we = data_wr_i && (state_q == ST_IDLE) && (int'(data_addr_i) < ND);

  // Taps leave in descending address order so the core's chain ends up row-major.
  assign tap_ra  = TA_W'(NT - 1 - int'(beat_q));
  assign data_ra = (state_q == ST_DATA) ? beat_q[DA_W-1:0] : '0;

  // A write landing on the same edge as start must be seen by the first tap beat.
  assign tap_rd  = (tap_we && tap_addr_i == tap_ra) ? tap_wdata_i : tap_mem[tap_ra];
  assign data_rd = data_mem[data_ra];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    res_count_d = res_count_q;
    err_d       = err_q;
    tap_vld_d   = 1'b0;
    tap_d       = '0;
    data_vld_d  = 1'b0;
    data_d      = '0;
    res_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_TAP;
          tap_vld_d   = 1'b1;
          tap_d       = tap_rd;
          beat_d      = CNT_W'(1);
          wait_d      = '0;
          res_count_d = '0;
          err_d       = 1'b0;
        end
      end
      ST_TAP: begin
        if (beat_q == NT_C) begin
          state_d    = ST_DATA;
          data_vld_d = 1'b1;
          data_d     = data_rd;
          beat_d     = CNT_W'(1);
        end else begin
          tap_vld_d = 1'b1;
          tap_d     = tap_rd;
          beat_d    = beat_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (beat_q == ND_C) begin
          state_d = ST_WAIT;
          beat_d  = '0;
        end else begin
          data_vld_d = 1'b1;
          data_d     = data_rd;
          beat_d     = beat_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        wait_d = wait_q + TO_W'(1);
        if (result_finish_i || res_count_q == NR_C || wait_q == TO_LAST) begin
          state_d = ST_DONE;
          if (!result_finish_i && res_count_q != NR_C) err_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Results arriving once the memory is full are dropped and flagged.
    if ((state_q == ST_DATA || state_q == ST_WAIT) && result_vld_i) begin
      if (res_count_q == NR_C) begin
        err_d = 1'b1;
      end else begin
        res_we      = 1'b1;
        res_count_d = res_count_q + RC_W'(1);
      end
    end
  end

  assign res_data_d = (int'(res_addr_i) < NR) ? res_mem[res_addr_i] : '0;

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      res_count_q <= '0;
      err_q       <= 1'b0;
      tap_vld_q   <= 1'b0;
      tap_q       <= '0;
      data_vld_q  <= 1'b0;
      data_q      <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      res_count_q <= res_count_d;
      err_q       <= err_d;
      tap_vld_q   <= tap_vld_d;
      tap_q       <= tap_d;
      data_vld_q  <= data_vld_d;
      data_q      <= data_d;
      res_data_q  <= res_data_d;
    end
  end

  // NOTE: memories carry no reset; their contents survive a reset by design.
  always_ff @(posedge clk) begin
    if (tap_we)  tap_mem[tap_addr_i]                <= tap_wdata_i;
    if (data_we) data_mem[data_addr_i]              <= data_wdata_i;
    if (res_we)  res_mem[res_count_q[RA_W-1:0]]     <= result_i;
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q;
  assign res_count_o = res_count_q;
  assign res_data_o  = res_data_q;
  assign tap_o       = tap_q;
  assign tap_vld_o   = tap_vld_q;
  assign data_o      = data_q;
  assign data_vld_o  = data_vld_q;

endmodule

// File: tb/tb_fir_host_seq.sv
// Directed bench for fir_host_seq: table of run scenarios with a behavioural core
// responder, plus hand-written reset-mid-run and result readback sequences.
module tb_fir_host_seq;

  localparam int NT = 9;
  localparam int ND = 256;
  localparam int NR = 196;
  localparam int E  = NT + ND + 1;   // first WAIT cycle, counted from the start edge

  logic        clk = 1'b0;
  logic        reset;
  logic        tap_wr_i;
  logic [3:0]  tap_addr_i;
  logic [7:0]  tap_wdata_i;
  logic        data_wr_i;
  logic [7:0]  data_addr_i;
  logic [15:0] data_wdata_i;
  logic        start_i;
  logic        busy_o, done_o, err_o;
  logic [7:0]  res_addr_i;
  logic [31:0] res_data_o;
  logic [7:0]  res_count_o;
  logic [7:0]  tap_o;
  logic        tap_vld_o;
  logic [15:0] data_o;
  logic        data_vld_o;
  logic [31:0] result_i;
  logic        result_vld_i, result_finish_i;

  fir_host_seq dut (
    .clk            (clk),
    .reset          (reset),
    .tap_wr_i       (tap_wr_i),
    .tap_addr_i     (tap_addr_i),
    .tap_wdata_i    (tap_wdata_i),
    .data_wr_i      (data_wr_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .res_addr_i     (res_addr_i),
    .res_data_o     (res_data_o),
    .res_count_o    (res_count_o),
    .tap_o          (tap_o),
    .tap_vld_o      (tap_vld_o),
    .data_o         (data_o),
    .data_vld_o     (data_vld_o),
    .result_i       (result_i),
    .result_vld_i   (result_vld_i),
    .result_finish_i(result_finish_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    kern;       // 0: taps 1..9, 1: identity, 2: keep memory as is
    bit    bypass;     // write tap[8] = -3 on the start edge
    int    n_res;      // results the responder emits from WAIT entry
    int    stride;     // cycles between emitted results
    int    fin;        // result_finish_i at E+fin (0 = never)
    bit    ill;        // pulse host writes/start while busy
    int    exp_count;
    bit    exp_err;
    int    exp_done;   // cycle of done_o, start edge ends cycle 0
  } run_vec_t;

  typedef struct {
    int          addr;
    logic [31:0] exp;
  } rd_vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic signed [7:0]  taps_m  [NT];
  logic signed [15:0] data_m  [ND];
  logic signed [7:0]  cap_tap [NT];
  logic signed [15:0] cap_data[ND];
  logic [31:0]        exp_res [NR];

  run_vec_t vecs [8];
  rd_vec_t  rds  [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Behaviour of the core: tap beat t lands at tap[r][c] with r*3+c = NT-1-t.
  function automatic logic [31:0] core_result(input int k);
    int acc = 0;
    int r = k / 14;
    int c = k % 14;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += int'(cap_tap[NT-1-(i*3+j)]) * int'(cap_data[(r+i)*16 + c + j]);
    return acc;
  endfunction

  // What the host intended to compute from the values it loaded.
  function automatic logic [31:0] model_result(input int k);
    int acc = 0;
    int r = k / 14;
    int c = k % 14;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += int'(taps_m[i*3+j]) * int'(data_m[(r+i)*16 + c + j]);
    return acc;
  endfunction

  task automatic load_taps(input int kern);
    if (kern == 2) return;
    for (int i = 0; i < NT; i++) begin
      taps_m[i] = (kern == 0) ? 8'(i + 1) : ((i == 4) ? 8'sd1 : 8'sd0);
      @(negedge clk);
      tap_wr_i    = 1'b1;
      tap_addr_i  = 4'(i);
      tap_wdata_i = taps_m[i];
    end
    @(negedge clk);
    tap_wr_i = 1'b0;
  endtask

  task automatic load_ramp();
    for (int a = 0; a < ND; a++) begin
      data_m[a] = 16'(a);
      @(negedge clk);
      data_wr_i    = 1'b1;
      data_addr_i  = 8'(a);
      data_wdata_i = data_m[a];
    end
    @(negedge clk);
    data_wr_i = 1'b0;
  endtask

  task automatic run_vec(input run_vec_t v);
    int cyc, done_cyc, idx, k, n_tap, n_data;
    int tap_bad, data_bad, busy_bad, res_bad;
    logic [31:0] done_err, done_cnt;
    logic signed [7:0]  exp_t;
    logic signed [15:0] exp_d;
    bit exp_tv, exp_dv, finished;

    load_taps(v.kern);
    @(negedge clk);
    start_i = 1'b1;
    if (v.bypass) begin
      tap_wr_i    = 1'b1;
      tap_addr_i  = 4'(NT - 1);
      tap_wdata_i = 8'hFD;
      taps_m[NT-1] = -8'sd3;
    end
    for (int r = 0; r < NR; r++) exp_res[r] = model_result(r);

    done_cyc = -1; n_tap = 0; n_data = 0; finished = 1'b0;
    tap_bad = 0; data_bad = 0; busy_bad = 0; done_err = '0; done_cnt = '0;

    for (cyc = 1; cyc <= 6000 && !finished; cyc++) begin
      @(negedge clk);
      start_i = 1'b0; tap_wr_i = 1'b0; data_wr_i = 1'b0;
      result_vld_i = 1'b0; result_finish_i = 1'b0;
      if (cyc == 1) begin
        check({v.name, ".err_cleared"}, err_o, 0);
        check({v.name, ".count_cleared"}, res_count_o, 0);
      end
      if (done_cyc >= 0) begin
        check({v.name, ".busy_after_done"}, busy_o, 0);
        check({v.name, ".done_one_cycle"}, done_o, 0);
        finished = 1'b1;
      end else begin
        exp_tv = (cyc <= NT);
        exp_t  = exp_tv ? taps_m[NT-cyc] : 8'sd0;
        if (tap_vld_o !== exp_tv || tap_o !== exp_t) tap_bad++;
        if (tap_vld_o && n_tap < NT) begin cap_tap[n_tap] = tap_o; n_tap++; end

        exp_dv = (cyc > NT) && (cyc <= NT + ND);
        exp_d  = exp_dv ? data_m[cyc-NT-1] : 16'sd0;
        if (data_vld_o !== exp_dv || data_o !== exp_d) data_bad++;
        if (data_vld_o && n_data < ND) begin cap_data[n_data] = data_o; n_data++; end

        if (!busy_o) busy_bad++;
        if (done_o) begin
          done_cyc = cyc;
          done_err = 32'(err_o);
          done_cnt = 32'(res_count_o);
        end else begin
          idx = cyc - E;
          if (v.n_res > 0 && cyc >= E && idx % v.stride == 0 && idx / v.stride < v.n_res) begin
            k = idx / v.stride;
            result_vld_i = 1'b1;
            result_i     = (k < NR) ? core_result(k) : 32'hDEADBEEF;
          end
          if (v.fin > 0 && cyc == E + v.fin) result_finish_i = 1'b1;
          if (v.ill) begin
            case (cyc)
              3:   begin tap_wr_i = 1'b1; tap_addr_i = 4'd0; tap_wdata_i = 8'd77; end
              12:  begin data_wr_i = 1'b1; data_addr_i = 8'd100; data_wdata_i = 16'h7777; end
              20:  start_i = 1'b1;
              300: begin tap_wr_i = 1'b1; tap_addr_i = 4'd4; tap_wdata_i = 8'd5; start_i = 1'b1; end
              default: ;
            endcase
          end
        end
      end
    end
    start_i = 1'b0; tap_wr_i = 1'b0; data_wr_i = 1'b0;
    result_vld_i = 1'b0; result_finish_i = 1'b0;

    check({v.name, ".finished_in_bound"}, 32'(finished), 1);
    check({v.name, ".done_cycle"}, done_cyc, v.exp_done);
    check({v.name, ".err_at_done"}, done_err, 32'(v.exp_err));
    check({v.name, ".count_at_done"}, done_cnt, v.exp_count);
    check({v.name, ".tap_stream_bad_cycles"}, tap_bad, 0);
    check({v.name, ".data_stream_bad_cycles"}, data_bad, 0);
    check({v.name, ".busy_low_during_run"}, busy_bad, 0);

    res_bad = 0;
    for (int r = 0; r < v.exp_count; r++) begin
      @(negedge clk);
      res_addr_i = 8'(r);
      @(negedge clk);
      if (res_data_o !== exp_res[r]) res_bad++;
    end
    check({v.name, ".stored_results_bad"}, res_bad, 0);
  endtask

  initial begin
    vecs[0] = '{"tap_order", 2, 1'b0, 196, 1, 0,  1'b0, 196, 1'b0, 463};
    vecs[1] = '{"bypass",    0, 1'b1, 196, 1, 0,  1'b0, 196, 1'b0, 463};
    vecs[2] = '{"e2e_ident", 1, 1'b0, 196, 2, 0,  1'b0, 196, 1'b0, 658};
    vecs[3] = '{"timeout",   2, 1'b0, 0,   1, 0,  1'b0, 0,   1'b1, 4362};
    vecs[4] = '{"overflow",  2, 1'b0, 197, 1, 0,  1'b0, 196, 1'b1, 463};
    vecs[5] = '{"finish",    2, 1'b0, 10,  1, 20, 1'b0, 10,  1'b0, 287};
    vecs[6] = '{"illegal",   2, 1'b0, 196, 2, 0,  1'b1, 196, 1'b0, 658};
    vecs[7] = '{"rerun",     2, 1'b0, 196, 2, 0,  1'b0, 196, 1'b0, 658};

    // Identity kernel over a ramp: result k = (k/14+1)*16 + (k%14+1).
    rds[0] = '{0,   32'd17};
    rds[1] = '{13,  32'd30};
    rds[2] = '{14,  32'd33};
    rds[3] = '{100, 32'd131};
    rds[4] = '{195, 32'd238};

    reset = 1'b1;
    tap_wr_i = 1'b0; tap_addr_i = '0; tap_wdata_i = '0;
    data_wr_i = 1'b0; data_addr_i = '0; data_wdata_i = '0;
    start_i = 1'b0; res_addr_i = '0;
    result_i = '0; result_vld_i = 1'b0; result_finish_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", busy_o, 0);
    check("reset.done", done_o, 0);
    check("reset.err", err_o, 0);
    check("reset.count", res_count_o, 0);
    check("reset.tap_vld", tap_vld_o, 0);
    check("reset.data_vld", data_vld_o, 0);
    check("reset.tap", tap_o, 0);
    check("reset.data", data_o, 0);
    reset = 1'b0;

    load_taps(0);
    load_ramp();

    // Reset in the middle of the data burst.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (58) @(negedge clk);
    check("rst_mid.data_vld_before", data_vld_o, 1);
    check("rst_mid.data_before", data_o, 49);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid.data_vld", data_vld_o, 0);
    check("rst_mid.busy", busy_o, 0);
    check("rst_mid.data", data_o, 0);
    check("rst_mid.count", res_count_o, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      res_addr_i = 8'(rds[i].addr);
      @(negedge clk);
      check($sformatf("readback[%0d]", rds[i].addr), res_data_o, rds[i].exp);
    end
    check("idle.busy", busy_o, 0);
    check("idle.count_retained", res_count_o, 196);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_host_seq.md
# fir_host_seq

Host-side sequencer for the 2D FIR DSP matrix core. It holds one tap set and one data frame in local memories and streams them into the core's `tap_i`/`data_i` inputs in the order the core's shift chains expect. It captures the core's `result_o`/`result_vld_o` stream into a result memory and exposes start/busy/done status plus a result readback port. It is the initiator/collector end of the core's tap/data/result interface.

## Interface
Parameters:
- TAP_ROW, 3, tap rows
- TAP_COL, 3, tap columns
- TAP_WIDTH, 8, tap bits (signed)
- DATA_ROW, 16, frame rows
- DATA_COL, 16, frame columns; DATA_ROW*DATA_COL ≤ 256 (core FIFO depth), elaboration error otherwise
- DATA_WIDTH, 16, sample bits (signed)
- TIMEOUT, 4096, max cycles in WAIT before abort

Derived values:
- NT = TAP_ROW*TAP_COL
- ND = DATA_ROW*DATA_COL
- NR = (DATA_ROW-TAP_ROW+1)*(DATA_COL-TAP_COL+1)

Ports (clock and reset first):
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- tap_wr_i  in  1  write tap memory
- tap_addr_i  in  $clog2(NT)  tap address; addr = r*TAP_COL+c
- tap_wdata_i  in  TAP_WIDTH  tap value
- data_wr_i  in  1  write data memory
- data_addr_i  in  $clog2(ND)  data address; addr = row*DATA_COL+col
- data_wdata_i  in  DATA_WIDTH  sample
- start_i  in  1  start one frame run
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle pulse at run end
- err_o  out  1  sticky: timeout or result overflow; cleared on start or reset
- res_addr_i  in  $clog2(NR)  result read address
- res_data_o  out  32  result at res_addr_i, 1-cycle read latency
- res_count_o  out  $clog2(NR+1)  results captured in current/last run
- tap_o  out  TAP_WIDTH  to core tap_i
- tap_vld_o  out  1  to core tap_vld_i
- data_o  out  DATA_WIDTH  to core data_i
- data_vld_o  out  1  to core data_vld_i
- result_i  in  32  from core result_o
- result_vld_i  in  1  from core result_vld_o
- result_finish_i  in  1  from core result_finish_o

## Operation
- FSM states: IDLE, TAP, DATA, WAIT, DONE.
- IDLE:
  - Host writes are accepted.
  - start_i moves the FSM to TAP, clears res_count_o and err_o, and resets the timeout counter.
- TAP:
  - Exactly NT consecutive cycles with tap_vld_o=1.
  - Beat t (0..NT-1) carries tap memory address NT-1-t (descending), so that tap address r*TAP_COL+c settles at core tap[r][c].
  - After the last beat, the FSM goes to DATA.
- DATA:
  - Exactly ND consecutive cycles with data_vld_o=1, ascending addresses 0..ND-1, no gaps.
  - The burst must be contiguous because the core pads with a delayed copy of data_vld.
  - After the last beat, the FSM goes to WAIT.
- WAIT:
  - Counts cycles. On result_finish_i, res_count_o==NR, or TIMEOUT cycles, the FSM goes to DONE.
  - On timeout, err_o is set.
- DONE:
  - done_o=1 for one cycle, then IDLE.
- Result capture, active in DATA and WAIT:
  - Each result_vld_i=1 writes result_i to result memory at res_count_o, then increments res_count_o.
  - Any result_vld_i when res_count_o==NR is dropped and sets err_o.
  - result_vld_i in IDLE, TAP or DONE is ignored.
- Host writes (tap_wr_i/data_wr_i) outside IDLE are ignored. Memories are not modified during a run.
- start_i outside IDLE is ignored.
- Simultaneous start_i and host write in IDLE: the write is applied, but TAP reads start on the next cycle and see the new value.
- Result memory reads via res_addr_i are valid in any state. The last run's results are retained until the next start.
- No arithmetic on results: values are stored as received, all 32 bits.

## Timing
- Reset values: busy_o=0, done_o=0, err_o=0, res_count_o=0, tap_vld_o=0, data_vld_o=0, tap_o=0, data_o=0; FSM=IDLE. res_data_o is undefined until the first read after reset.
- All core-facing outputs are registered.
- tap_o, data_o and res_data_o are forced to 0 by reset and otherwise carry memory read data.
- start_i sampled at cycle 0 → busy_o=1 at cycle 1 → tap_vld_o=1 at cycles 1..NT.
- data_vld_o=1 at cycles NT+1..NT+ND, immediately after the tap beats, with no idle cycle.
- tap_o and data_o hold 0 whenever the corresponding valid is 0.
- done_o rises one cycle after the WAIT exit condition. busy_o falls together with done_o.
- Reset asserted mid-run: on the next edge all outputs take their reset values and any partial burst is abandoned. Memories are not cleared.
- Read port: res_addr_i at cycle n → res_data_o at cycle n+1.

## Test plan
- Reset mid-DATA (cycle NT+50):
  - Next cycle: data_vld_o=0, busy_o=0.
  - A new start replays the full NT+ND sequence correctly.
- Tap ordering: write taps 1..9 at addresses 0..8, start → tap_o sequence 9,8,…,1 on cycles 1..9. data_o is 0..255 (ramp loaded) on cycles 10..265 with data_vld_o contiguous.
- End-to-end with core model:
  - Setup: identity kernel (addr 4 = 1, others 0) and ramp frame data[a]=a.
  - Expected: 196 results; result k = (r+1)*16+(c+1) with r=k/14, c=k%14.
  - Then done_o pulses, err_o=0 and res_count_o=196.
- Timeout: responder never returns results → done_o at WAIT entry + 4096 cycles, err_o=1, res_count_o=0.
- Overflow: responder emits 197 valid results → first 196 stored, err_o=1, done_o after the 196th.
- Illegal access during run:
  - tap_wr_i and data_wr_i and start_i pulsed while busy are ignored.
  - A second run with the same memory yields identical results.
